// File: rtl/julia_pkg.sv
`default_nettype none
// ============================================================================
// Module   : julia_pkg
// Purpose  : Shared types and constants for the pixel write path.
//            - arb_state_t  : arbiter state encoding (IDLE / CALC / WRITE)
//            - FRAME_STRIDE : pixels per frame-buffer row
// Revision : 1.0 - initial release
// ============================================================================
package julia_pkg;

    localparam logic [31:0] FRAME_STRIDE = 32'd641;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/addr_calculator.sv
`default_nettype none
// ============================================================================
// Module   : addr_calculator
// Purpose  : Combinational frame-buffer address for one pixel:
//            ((y*FRAME_STRIDE + x) * pixel_size + base_offset) mod 2^32
// Ports    : i_x, i_y        - pixel coordinates (not range-checked)
//            i_pixel_size    - bytes per pixel
//            i_base_offset   - frame-buffer base address
//            o_address       - resulting byte address
// Revision : 1.0 - initial release
// ============================================================================
module addr_calculator
    import julia_pkg::*;
#(
    parameter int PIXELBITS = 4
) (
    input  logic [9:0]           i_x,
    input  logic [9:0]           i_y,
    input  logic [PIXELBITS-1:0] i_pixel_size,
    input  logic [31:0]          i_base_offset,
    output logic [31:0]          o_address
);

    logic [31:0] w_linear;
    logic [31:0] w_size;

    // x beyond the row width is not clipped: it simply aliases into the
    // following row through the linear index.
    assign w_linear  = ({22'd0, i_y} * FRAME_STRIDE) + {22'd0, i_x};
    assign w_size    = {{(32-PIXELBITS){1'b0}}, i_pixel_size};
    assign o_address = (w_linear * w_size) + i_base_offset;

endmodule
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_write_arbiter
// Purpose  : Round-robin arbiter that accepts pixels from NREQ requesters,
//            computes their frame-buffer address and issues one Avalon-MM
//            write per pixel.  Service is grant -> calc -> write (3 cycles
//            minimum per pixel).
// Ports    : clk, reset            - clock, synchronous active-high reset
//            req_valid/x/y/color   - per-requester pixel (packed vectors)
//            req_ready             - one-hot accept strobe (grant cycle only)
//            pixel_size            - bytes per pixel (sampled in CALC)
//            base_offset           - frame-buffer base (sampled in CALC)
//            avm_*                 - Avalon-MM write master
//            pixels_written        - completed-write counter (optional)
// Options  : define PIXEL_WRITE_COUNT_EN to add the pixels_written counter.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_write_arbiter
    import julia_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int PIXELBITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*10-1:0]   req_x,
    input  logic [NREQ*10-1:0]   req_y,
    input  logic [NREQ*32-1:0]   req_color,
    output logic [NREQ-1:0]      req_ready,
    input  logic [PIXELBITS-1:0] pixel_size,
    input  logic [31:0]          base_offset,
    output logic [31:0]          avm_address,
    output logic                 avm_write,
    output logic [31:0]          avm_writedata,
    input  logic                 avm_waitrequest
`ifdef PIXEL_WRITE_COUNT_EN
    ,
    output logic [31:0]          pixels_written
`endif
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       r_state;
    logic [PTRW-1:0]  r_ptr;          // first index to consider next time
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic [31:0]      r_address;
    logic [31:0]      r_wdata;
    logic             r_write;

    logic [9:0]       w_x     [NREQ];
    logic [9:0]       w_y     [NREQ];
    logic [31:0]      w_color [NREQ];
    logic             w_grant_found;
    logic [PTRW-1:0]  w_grant_idx;
    logic [PTRW-1:0]  w_cand;
    logic [NREQ-1:0]  w_ready;
    logic [31:0]      w_address;

    // Unpack the flat requester buses for clean indexed selection.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_x[gi]     = req_x[gi*10 +: 10];
            assign w_y[gi]     = req_y[gi*10 +: 10];
            assign w_color[gi] = req_color[gi*32 +: 32];
        end
    endgenerate

    // Round-robin search starting at r_ptr.  Scanning from the farthest
    // candidate back to the nearest lets the nearest valid one win.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = PTRW'((int'(r_ptr) + k) % NREQ);
            if (req_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // The accept strobe is a same-cycle handshake with req_valid so a
    // requester that drops valid before this cycle is never served.
    always_comb begin
        w_ready = '0;
        if (!reset && (r_state == IDLE) && w_grant_found) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    addr_calculator #(
        .PIXELBITS     (PIXELBITS)
    ) u_addr_calculator (
        .i_x           (r_x),
        .i_y           (r_y),
        .i_pixel_size  (pixel_size),
        .i_base_offset (base_offset),
        .o_address     (w_address)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_address <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_found) begin
                        r_x     <= w_x[w_grant_idx];
                        r_y     <= w_y[w_grant_idx];
                        r_wdata <= w_color[w_grant_idx];
                        if (w_grant_idx == PTRW'(NREQ - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= w_grant_idx + 1'b1;
                        end
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_address <= w_address;
                    r_write   <= 1'b1;
                    r_state   <= WRITE;
                end
                WRITE: begin
                    // Address and data are untouched here, so they stay
                    // stable for as long as the slave stalls.
                    if (!avm_waitrequest) begin
                        r_write <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_write <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef PIXEL_WRITE_COUNT_EN
    logic [31:0] r_pixels_written;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixels_written <= '0;
        end else if ((r_state == WRITE) && !avm_waitrequest) begin
            r_pixels_written <= r_pixels_written + 32'd1;
        end
    end

    assign pixels_written = r_pixels_written;
`endif

    assign req_ready     = w_ready;
    assign avm_address   = r_address;
    assign avm_write     = r_write;
    assign avm_writedata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_write_arbiter
// Purpose  : Directed self-checking bench for pixel_write_arbiter
//            (NREQ=2, PIXELBITS=4).  Covers reset values, single pixel
//            address/latency, 32-bit address wrap, backpressure, round-robin
//            fairness, reset during WRITE and (with PIXEL_WRITE_COUNT_EN)
//            the completed-write counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_write_arbiter;

    localparam int NREQ      = 2;
    localparam int PIXELBITS = 4;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*10-1:0]   req_x;
    logic [NREQ*10-1:0]   req_y;
    logic [NREQ*32-1:0]   req_color;
    logic [NREQ-1:0]      req_ready;
    logic [PIXELBITS-1:0] pixel_size;
    logic [31:0]          base_offset;
    logic [31:0]          avm_address;
    logic                 avm_write;
    logic [31:0]          avm_writedata;
    logic                 avm_waitrequest;
`ifdef PIXEL_WRITE_COUNT_EN
    logic [31:0]          pixels_written;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pixel_write_arbiter #(
        .NREQ            (NREQ),
        .PIXELBITS       (PIXELBITS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_x           (req_x),
        .req_y           (req_y),
        .req_color       (req_color),
        .req_ready       (req_ready),
        .pixel_size      (pixel_size),
        .base_offset     (base_offset),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
`ifdef PIXEL_WRITE_COUNT_EN
        ,
        .pixels_written  (pixels_written)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [9:0] x, input logic [9:0] y,
                           input logic [31:0] color);
        req_x[idx*10 +: 10]     = x;
        req_y[idx*10 +: 10]     = y;
        req_color[idx*32 +: 32] = color;
    endtask

    initial begin
        reset           = 1'b1;
        req_valid       = '0;
        req_x           = '0;
        req_y           = '0;
        req_color       = '0;
        pixel_size      = '0;
        base_offset     = '0;
        avm_waitrequest = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_data", avm_writedata, 0);
        chk("rst_ready", req_ready, 0);
        req_valid = 2'b01;
        #1;
        chk("rst_ready_valid", req_ready, 0);

        // ---------------- single pixel: req0 x=2 y=1 size=4 off=0x1000 ----
        set_req(0, 10'd2, 10'd1, 32'hDEAD_BEEF);
        pixel_size  = 4'd4;
        base_offset = 32'h0000_1000;
        reset       = 1'b0;
        #1;
        chk("single_grant", req_ready, 2'b01);
        step();                           // -> CALC
        req_valid = 2'b00;
        #1;
        chk("single_calc_ready", req_ready, 0);
        chk("single_calc_write", avm_write, 0);
        step();                           // -> WRITE (third cycle)
        chk("single_write", avm_write, 1);
        chk("single_addr", avm_address, 32'h0000_1A0C);
        chk("single_data", avm_writedata, 32'hDEAD_BEEF);
        step();                           // -> IDLE
        chk("single_done", avm_write, 0);

        // ---------------- wrap: off=0xFFFFFFF0 x=4 y=0 size=4 ----------------
        set_req(0, 10'd4, 10'd0, 32'h1234_5678);
        base_offset = 32'hFFFF_FFF0;
        req_valid   = 2'b01;
        #1;
        chk("wrap_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        chk("wrap_write", avm_write, 1);
        chk("wrap_addr", avm_address, 32'h0000_0000);
        step();

        // ---------------- backpressure (pointer now at 1) --------------------
        set_req(0, 10'd7, 10'd0, 32'h1111_1111);   // addr 7*2 = 0xE
        set_req(1, 10'd5, 10'd3, 32'hCAFE_F00D);   // (3*641+5)*2 = 0xF10
        pixel_size      = 4'd2;
        base_offset     = 32'h0;
        avm_waitrequest = 1'b1;
        req_valid       = 2'b11;
        #1;
        chk("bp_grant", req_ready, 2'b10);
        step();                           // CALC
        req_valid = 2'b01;
        #1;
        chk("bp_calc_ready", req_ready, 0);
        step();                           // WRITE
        for (int i = 0; i < 5; i++) begin
            chk("bp_write", avm_write, 1);
            chk("bp_addr", avm_address, 32'h0000_0F10);
            chk("bp_data", avm_writedata, 32'hCAFE_F00D);
            chk("bp_ready", req_ready, 0);
            step();
        end
        avm_waitrequest = 1'b0;
        #1;
        chk("bp_release_write", avm_write, 1);
        req_valid = 2'b11;
        step();                           // IDLE, next grant cycle

        // ---------------- fairness: both valid, grants alternate -------------
        for (int i = 0; i < 4; i++) begin
            chk("fair_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            chk("fair_calc_ready", req_ready, 0);
            step();
            chk("fair_write", avm_write, 1);
            chk("fair_write_ready", req_ready, 0);
            chk("fair_addr", avm_address, (i % 2 == 0) ? 32'h0000_000E : 32'h0000_0F10);
            chk("fair_data", avm_writedata, (i % 2 == 0) ? 32'h1111_1111 : 32'hCAFE_F00D);
            step();
        end
        chk("fair_grant5", req_ready, 2'b01);
`ifdef PIXEL_WRITE_COUNT_EN
        chk("count_7", pixels_written, 32'd7);
`endif

        // ---------------- reset mid-WRITE ------------------------------------
        step();                           // CALC for req0
        avm_waitrequest = 1'b1;
        step();                           // WRITE, stalled
        chk("mid_write", avm_write, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_write", avm_write, 0);
        chk("mid_rst_addr", avm_address, 0);
        chk("mid_rst_ready", req_ready, 0);
`ifdef PIXEL_WRITE_COUNT_EN
        chk("count_rst", pixels_written, 32'd0);
`endif
        reset           = 1'b0;
        avm_waitrequest = 1'b0;
        #1;
        chk("post_rst_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        chk("post_rst_data", avm_writedata, 32'h1111_1111);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
